serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of payload bits per frame (legal range 1-16).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the clock cycles per serial bit (legal range 1-65535).
REQ-003 Port clock SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be: input, 1 bit, asynchronous active-low reset (0 = in reset).
REQ-005 Port tx_valid SHALL be: input, 1 bit, high when the producer presents a word.
REQ-006 Port tx_data SHALL be: input, DATA_WIDTH bits, the word to send.
REQ-007 Port tx_ready SHALL be: output, 1 bit, high when the block can accept a word.
REQ-008 Port tx_serial SHALL be: output, 1 bit, the serial line, idle high.
REQ-009 Port tx_busy SHALL be: output, 1 bit, high while a frame is on the line.
REQ-010 Port tx_done SHALL be: output, 1 bit, one-cycle pulse at frame completion.

Function
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-012 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-013 A word SHALL be accepted at a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be latched into an internal shift register at that edge.
REQ-014 tx_ready SHALL be 1 only in IDLE; tx_busy SHALL equal NOT tx_ready.
REQ-015 On the accepting edge (E0), state SHALL become START and tx_serial SHALL become 0, and tx_ready SHALL fall.
REQ-016 START SHALL last CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA SHALL send DATA_WIDTH bits LSB first, each held CLKS_PER_BIT cycles, then STOP.
REQ-018 STOP SHALL drive tx_serial=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 Return to IDLE SHALL occur at edge E0+(DATA_WIDTH+2)*CLKS_PER_BIT; at that edge tx_done SHALL rise for exactly one cycle and tx_ready SHALL rise.
REQ-020 tx_serial SHALL be 1 in IDLE at all times.
REQ-021 tx_valid and tx_data changes while tx_busy=1 SHALL be ignored; no queuing.
REQ-022 A word offered in the tx_done cycle SHALL be accepted (back-to-back); the line then shows exactly one high IDLE cycle between the stop bit and the next start bit.
REQ-023 Bit-period and bit-index counters SHALL wrap to 0 at each bit/state boundary with no skipped or repeated cycles; CLKS_PER_BIT=1 SHALL give one cycle per bit.

Reset
REQ-024 While reset=0, state SHALL be IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, counters and shift register 0, independent of clock.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (tx_serial high asynchronously); no tx_done SHALL be produced for it.
REQ-026 After reset deasserts, the first rising edge SHALL be able to accept a word.

Verification
REQ-027 Defaults, send 0xA5 -> tx_serial per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; tx_done at E0+40; tx_ready low E0 through E0+39.
REQ-028 Back-to-back 0x00 then 0xFF with tx_valid held -> second start bit at E0+41; second frame line: 0, eight 1s, 1.
REQ-029 tx_valid pulsed with 0x3C at E0+10 while busy -> ignored; frame unchanged; only one tx_done.
REQ-030 reset=0 at E0+17 (mid-DATA) -> tx_serial=1 immediately, tx_ready=1, no tx_done; next word after release sent correctly.
REQ-031 CLKS_PER_BIT=1, DATA_WIDTH=8, send 0x81 -> line 0,1,0,0,0,0,0,0,1,1 one cycle each; tx_done at E0+10.
REQ-032 tx_valid held 0 for 100 cycles after reset -> tx_serial=1, tx_ready=1, tx_done=0 throughout.

Source files
------------

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_WIDTH payload bits LSB first, stop bit,
// each held CLKS_PER_BIT clocks. Every output is driven directly by a flop.
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [15:0]   CNT_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [15:0]           cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic                  serial_n, ready_n, done_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      tx_serial <= serial_n;
      tx_ready  <= ready_n;
      tx_busy   <= !ready_n;
      tx_done   <= done_n;
    end
  end

  // Next-state logic also computes the next value of every output so that
  // the outputs can be registered without lagging the state by a cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sh_n     = sh;
    serial_n = tx_serial;
    ready_n  = tx_ready;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        serial_n = 1'b1;
        ready_n  = 1'b1;
        if (tx_valid && tx_ready) begin
          sh_n     = tx_data;
          state_n  = START;
          serial_n = 1'b0;
          ready_n  = 1'b0;
          cnt_n    = '0;
          idx_n    = '0;
        end
      end
      START: begin
        if (cnt == CNT_MAX) begin
          cnt_n    = '0;
          idx_n    = '0;
          state_n  = DATA;
          serial_n = sh[0];
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_n = '0;
          if (idx == IDX_MAX) begin
            idx_n    = '0;
            state_n  = STOP;
            serial_n = 1'b1;
          end else begin
            idx_n    = idx + 1'b1;
            sh_n     = sh >> 1;
            serial_n = sh_n[0];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == CNT_MAX) begin
          cnt_n    = '0;
          sh_n     = '0;
          state_n  = IDLE;
          serial_n = 1'b1;
          ready_n  = 1'b1;
          done_n   = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = 1'b1;
        ready_n  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: one default instance and one with
// CLKS_PER_BIT=1; expected line/done cycles are queued at word acceptance.
module tb_serial_tx;

  localparam int W  = 8;
  localparam int C0 = 4;
  localparam int C1 = 1;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic         rdy0, ser0, busy0, done0;
  logic         rdy1, ser1, busy1, done1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit line0[$];
  bit line1[$];
  int dq0[$];
  int dq1[$];

  serial_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C0)) dut0 (
    .clock(clock), .reset(reset), .tx_valid(v0), .tx_data(d0),
    .tx_ready(rdy0), .tx_serial(ser0), .tx_busy(busy0), .tx_done(done0)
  );

  serial_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C1)) dut1 (
    .clock(clock), .reset(reset), .tx_valid(v1), .tx_data(d1),
    .tx_ready(rdy1), .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int which, input logic [W-1:0] d, input int e0);
    int c;
    bit b;
    c = (which == 0) ? C0 : C1;
    for (int i = 0; i < W + 2; i++) begin
      if (i == 0)          b = 1'b0;
      else if (i == W + 1) b = 1'b1;
      else                 b = d[i-1];
      for (int k = 0; k < c; k++) begin
        if (which == 0) line0.push_back(b);
        else            line1.push_back(b);
      end
    end
    if (which == 0) dq0.push_back(e0 + (W + 2) * c);
    else            dq1.push_back(e0 + (W + 2) * c);
  endtask

  // Presents a word and waits for the handshake edge; e0 is that edge's cycle.
  task automatic send(input int which, input logic [W-1:0] d, output int e0);
    logic acc;
    e0 = -1;
    if (which == 0) begin v0 = 1'b1; d0 = d; end
    else            begin v1 = 1'b1; d1 = d; end
    for (int i = 0; i < 200; i++) begin
      acc = (which == 0) ? rdy0 : rdy1;
      @(posedge clock);
      #1;
      if (acc) begin
        e0 = cyc;
        break;
      end
    end
    if (which == 0) v0 = 1'b0;
    else            v1 = 1'b0;
    if (e0 < 0) check("send_timeout", 0, 1);
    else        push_frame(which, d, e0);
  endtask

  task automatic drain(input int which);
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      empty = (which == 0) ? (line0.size() == 0 && dq0.size() == 0)
                           : (line1.size() == 0 && dq1.size() == 0);
      if (empty) break;
    end
    check("drain_timeout", empty, 1);
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    check("busy0", busy0, line0.size() > 0);
    check("ready0", rdy0, line0.size() == 0);
    if (line0.size() > 0) check("line0", ser0, line0.pop_front());
    else                  check("idle0", ser0, 1);
    if (done0) begin
      if (dq0.size() == 0) check("done0_spurious", 1, 0);
      else                 check("done0_cyc", cyc, dq0.pop_front());
    end
  end

  always @(negedge clock) begin
    check("busy1", busy1, line1.size() > 0);
    check("ready1", rdy1, line1.size() == 0);
    if (line1.size() > 0) check("line1", ser1, line1.pop_front());
    else                  check("idle1", ser1, 1);
    if (done1) begin
      if (dq1.size() == 0) check("done1_spurious", 1, 0);
      else                 check("done1_cyc", cyc, dq1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, eb, rel;
    repeat (3) @(negedge clock);
    check("rst_serial", ser0, 1);
    check("rst_ready", rdy0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    reset = 1'b1;

    // idle with tx_valid low: monitors check line high, ready high, no done
    repeat (100) @(negedge clock);

    send(0, 8'hA5, ea);
    drain(0);

    send(0, 8'h00, ea);
    send(0, 8'hFF, eb);
    check("b2b_start", eb, ea + (W + 2) * C0 + 1);
    drain(0);

    // word offered mid-frame must not be taken
    send(0, 8'h5A, ea);
    repeat (9) @(posedge clock);
    @(negedge clock);
    v0 = 1'b1;
    d0 = 8'h3C;
    @(negedge clock);
    v0 = 1'b0;
    drain(0);

    // reset in the middle of the data bits
    send(0, 8'hC3, ea);
    repeat (17) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_serial", ser0, 1);
    check("abort_ready", rdy0, 1);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    line0.delete();
    dq0.delete();
    line1.delete();
    dq1.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    rel = cyc;
    send(0, 8'h3C, ea);
    check("first_edge", ea, rel + 1);
    drain(0);

    send(1, 8'h81, ea);
    drain(1);
    send(1, 8'h00, ea);
    send(1, 8'hFF, eb);
    check("b2b1_start", eb, ea + (W + 2) * C1 + 1);
    drain(1);

    repeat (5) @(negedge clock);
    check("q0_empty", line0.size() + dq0.size(), 0);
    check("q1_empty", line1.size() + dq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
